// File: rtl/alarm_ctrl_pkg.sv
// Shared types and constants for the alarm edit sequencer.
// State codes, field codes, BCD limits and BCD sanity helpers.
package alarm_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EDIT_H,
        EDIT_M,
        EDIT_S,
        COMMIT
    } state_t;

    localparam logic [1:0] FIELD_HOUR = 2'd0;
    localparam logic [1:0] FIELD_MIN  = 2'd1;
    localparam logic [1:0] FIELD_SEC  = 2'd2;
    localparam logic [1:0] FIELD_NONE = 2'd3;

    localparam logic [7:0] HOUR_MAX_BCD   = 8'h23;
    localparam logic [7:0] MINSEC_MAX_BCD = 8'h59;

    localparam int NUM_ALARMS = 3;

    // Digit-wise BCD order matches numeric order once both digits are valid.
    function automatic logic bcd_ok(
        input logic [7:0] v,
        input logic [7:0] max_bcd
    );
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9)
            && (v <= max_bcd);
    endfunction

    function automatic logic [7:0] bcd_clean(
        input logic [7:0] v,
        input logic [7:0] max_bcd
    );
        return bcd_ok(v, max_bcd) ? v : 8'h00;
    endfunction

endpackage

// File: rtl/alarm_ctrl_if.sv
// Button, ring, preload and edit-result bundle of the alarm sequencer.
// slave = the sequencer, master = the debouncers / alarm block side.
interface alarm_ctrl_if;

    logic       btn_mode;
    logic       btn_next;
    logic       btn_inc;
    logic       btn_dec;
    logic       btn_ok;
    logic       ring_in;
    logic [7:0] cur_hour_bcd;
    logic [7:0] cur_minute_bcd;
    logic [7:0] cur_second_bcd;
    logic [1:0] selected_alarm;
    logic       set;
    logic [7:0] hour_bcd_out;
    logic [7:0] minute_bcd_out;
    logic [7:0] second_bcd_out;
    logic       edit_active;
    logic [1:0] edit_field;
    logic       cancel;
    logic       blink;

    modport master (
        output btn_mode, btn_next, btn_inc, btn_dec, btn_ok,
        output ring_in,
        output cur_hour_bcd, cur_minute_bcd, cur_second_bcd,
        input  selected_alarm, set,
        input  hour_bcd_out, minute_bcd_out, second_bcd_out,
        input  edit_active, edit_field, cancel, blink
    );

    modport slave (
        input  btn_mode, btn_next, btn_inc, btn_dec, btn_ok,
        input  ring_in,
        input  cur_hour_bcd, cur_minute_bcd, cur_second_bcd,
        output selected_alarm, set,
        output hour_bcd_out, minute_bcd_out, second_bcd_out,
        output edit_active, edit_field, cancel, blink
    );

endinterface

// File: rtl/alarm_ctrl_bcd_field_step.sv
// Combinational BCD +1/-1 with wrap at 00 and max_bcd_i.
// Invalid or out-of-range input is treated as 00.
module bcd_field_step
    import alarm_ctrl_pkg::*;
(
    input  logic [7:0] value_i,
    input  logic [7:0] max_bcd_i,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [7:0] value_o
);

    logic [7:0] v;

    always_comb begin
        v       = bcd_clean(value_i, max_bcd_i);
        value_o = v;
        if (inc_i) begin
            if (v == max_bcd_i)
                value_o = 8'h00;
            else if (v[3:0] == 4'd9)
                value_o = {v[7:4] + 4'd1, 4'd0};
            else
                value_o = v + 8'd1;
        end else if (dec_i) begin
            if (v == 8'h00)
                value_o = max_bcd_i;
            else if (v[3:0] == 4'd0)
                value_o = {v[7:4] - 4'd1, 4'd9};
            else
                value_o = v - 8'd1;
        end
    end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm slot browse/edit/commit sequencer with ring cancel.
// Optional blink output enabled by `define ALARM_CTRL_BLINK_EN.
module alarm_ctrl
    import alarm_ctrl_pkg::*;
#(
    parameter int LOAD_WAIT      = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000_000,
    parameter int BLINK_HALF     = 25_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    alarm_ctrl_if.slave  bus
);

    localparam int LW_W = $clog2(LOAD_WAIT + 1);
    localparam int TW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [LW_W-1:0] LOAD_LAST = LW_W'(LOAD_WAIT - 1);
    localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]      SEL_LAST  = 2'(NUM_ALARMS - 1);

    if (LOAD_WAIT < 1 || TIMEOUT_CYCLES < 2 || BLINK_HALF < 1)
    begin : g_bad_param
        $error("alarm_ctrl: parameter out of range");
    end

    state_t          state_q, state_d;
    logic [1:0]      sel_q, sel_d;
    logic [7:0]      hour_q, hour_d;
    logic [7:0]      min_q, min_d;
    logic [7:0]      sec_q, sec_d;
    logic [LW_W-1:0] load_q, load_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            set_q, set_d;
    logic            cancel_q, cancel_d;
    logic            active_q, active_d;
    logic [1:0]      field_q, field_d;

    logic any_btn, act;
    logic p_mode, p_ok, p_next, p_inc, p_dec;
    logic [7:0] fld_val, fld_max, step_val;

    // A button during ring only cancels the ring; it never reaches the FSM.
    assign any_btn = bus.btn_mode | bus.btn_ok | bus.btn_next
                   | bus.btn_inc | bus.btn_dec;
    assign act      = any_btn & ~bus.ring_in;
    assign cancel_d = any_btn & bus.ring_in;

    assign p_mode = act & bus.btn_mode;
    assign p_ok   = act & bus.btn_ok & ~bus.btn_mode;
    assign p_next = act & bus.btn_next & ~bus.btn_mode & ~bus.btn_ok;
    assign p_inc  = act & bus.btn_inc & ~bus.btn_mode & ~bus.btn_ok
                  & ~bus.btn_next;
    assign p_dec  = act & bus.btn_dec & ~bus.btn_mode & ~bus.btn_ok
                  & ~bus.btn_next & ~bus.btn_inc;

    always_comb begin
        fld_val = hour_q;
        fld_max = HOUR_MAX_BCD;
        unique case (state_q)
            EDIT_M:  begin fld_val = min_q; fld_max = MINSEC_MAX_BCD; end
            EDIT_S:  begin fld_val = sec_q; fld_max = MINSEC_MAX_BCD; end
            default: ;
        endcase
    end

    bcd_field_step u_step (
        .value_i   (fld_val),
        .max_bcd_i (fld_max),
        .inc_i     (p_inc),
        .dec_i     (p_dec),
        .value_o   (step_val)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        load_d  = load_q;
        tmo_d   = tmo_q;
        set_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                unique case (1'b1)
                    p_mode: begin
                        state_d = LOAD;
                        load_d  = '0;
                        tmo_d   = '0;
                    end
                    p_inc: sel_d = (sel_q == SEL_LAST) ? 2'd0 : sel_q + 2'd1;
                    p_dec: sel_d = (sel_q == 2'd0) ? SEL_LAST : sel_q - 2'd1;
                    default: ;
                endcase
            end
            LOAD: begin
                if (p_mode) begin
                    state_d = IDLE;
                end else if (load_q == LOAD_LAST) begin
                    hour_d  = bcd_clean(bus.cur_hour_bcd, HOUR_MAX_BCD);
                    min_d   = bcd_clean(bus.cur_minute_bcd, MINSEC_MAX_BCD);
                    sec_d   = bcd_clean(bus.cur_second_bcd, MINSEC_MAX_BCD);
                    state_d = EDIT_H;
                end else begin
                    load_d = load_q + LW_W'(1);
                end
            end
            EDIT_H, EDIT_M, EDIT_S: begin
                if (act) begin
                    tmo_d = '0;
                    unique case (1'b1)
                        p_mode: state_d = IDLE;
                        p_ok: begin
                            state_d = COMMIT;
                            set_d   = 1'b1;
                        end
                        p_next: begin
                            unique case (state_q)
                                EDIT_H:  state_d = EDIT_M;
                                EDIT_M:  state_d = EDIT_S;
                                default: state_d = EDIT_H;
                            endcase
                        end
                        p_inc, p_dec: begin
                            unique case (state_q)
                                EDIT_M:  min_d  = step_val;
                                EDIT_S:  sec_d  = step_val;
                                default: hour_d = step_val;
                            endcase
                        end
                        default: ;
                    endcase
                end else if (tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        active_d = (state_d != IDLE);
        field_d  = FIELD_NONE;
        unique case (state_d)
            EDIT_H:  field_d = FIELD_HOUR;
            EDIT_M:  field_d = FIELD_MIN;
            EDIT_S:  field_d = FIELD_SEC;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= 2'd0;
            hour_q   <= 8'h00;
            min_q    <= 8'h00;
            sec_q    <= 8'h00;
            load_q   <= '0;
            tmo_q    <= '0;
            set_q    <= 1'b0;
            cancel_q <= 1'b0;
            active_q <= 1'b0;
            field_q  <= FIELD_NONE;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            hour_q   <= hour_d;
            min_q    <= min_d;
            sec_q    <= sec_d;
            load_q   <= load_d;
            tmo_q    <= tmo_d;
            set_q    <= set_d;
            cancel_q <= cancel_d;
            active_q <= active_d;
            field_q  <= field_d;
        end
    end

    assign bus.selected_alarm = sel_q;
    assign bus.set            = set_q;
    assign bus.hour_bcd_out   = hour_q;
    assign bus.minute_bcd_out = min_q;
    assign bus.second_bcd_out = sec_q;
    assign bus.edit_active    = active_q;
    assign bus.edit_field     = field_q;
    assign bus.cancel         = cancel_q;

`ifdef ALARM_CTRL_BLINK_EN
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_HALF - 1);

    logic          blink_q;
    logic [BW-1:0] blk_q;
    logic          in_edit_d, in_edit_q;

    assign in_edit_d = (state_d == EDIT_H) || (state_d == EDIT_M)
                    || (state_d == EDIT_S);
    assign in_edit_q = (state_q == EDIT_H) || (state_q == EDIT_M)
                    || (state_q == EDIT_S);

    // A step restarts the phase with the field shown, so the new value is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_q <= 1'b0;
            blk_q   <= '0;
        end else if (!in_edit_d) begin
            blink_q <= 1'b0;
            blk_q   <= '0;
        end else if (in_edit_q && (p_inc || p_dec)) begin
            blink_q <= 1'b1;
            blk_q   <= '0;
        end else if (blk_q == BLK_LAST) begin
            blink_q <= ~blink_q;
            blk_q   <= '0;
        end else begin
            blk_q <= blk_q + BW'(1);
        end
    end

    assign bus.blink = blink_q;
`else
    assign bus.blink = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: directed plan plus random buttons
// compared against a decimal-arithmetic reference model.
module tb_alarm_ctrl;

    localparam int LW = 4;
    localparam int TO = 100;

    localparam int PH_IDLE   = 0;
    localparam int PH_LOAD   = 1;
    localparam int PH_EDIT   = 2;
    localparam int PH_COMMIT = 3;

    localparam logic [4:0] B_NONE = 5'b00000;
    localparam logic [4:0] B_MODE = 5'b10000;
    localparam logic [4:0] B_OK   = 5'b01000;
    localparam logic [4:0] B_NEXT = 5'b00100;
    localparam logic [4:0] B_INC  = 5'b00010;
    localparam logic [4:0] B_DEC  = 5'b00001;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alarm_ctrl_if bus ();

    alarm_ctrl #(
        .LOAD_WAIT      (LW),
        .TIMEOUT_CYCLES (TO),
        .BLINK_HALF     (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int m_ph, m_sel, m_h, m_m, m_s, m_fld, m_left, m_idle;
    bit e_set, e_cancel;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] i2b(input int n);
        logic [3:0] hi, lo;
        hi = 4'(n / 10);
        lo = 4'(n % 10);
        return {hi, lo};
    endfunction

    function automatic int san(input logic [7:0] v, input int maxv);
        int n;
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9) return 0;
        n = int'(v[7:4]) * 10 + int'(v[3:0]);
        return (n > maxv) ? 0 : n;
    endfunction

    function automatic logic [7:0] rand_bcd(input int maxv);
        if ($urandom_range(0, 3) != 0)
            return i2b(int'($urandom_range(0, maxv)));
        return 8'($urandom);
    endfunction

    task automatic model_reset();
        m_ph = PH_IDLE; m_sel = 0;
        m_h = 0; m_m = 0; m_s = 0;
        m_fld = 0; m_left = 0; m_idle = 0;
        e_set = 0; e_cancel = 0;
    endtask

    task automatic bump(input int d);
        case (m_fld)
            0:       m_h = (m_h + 24 + d) % 24;
            1:       m_m = (m_m + 60 + d) % 60;
            default: m_s = (m_s + 60 + d) % 60;
        endcase
    endtask

    task automatic model_step();
        bit md, ok, nx, in, dc, any, act;
        md = bus.btn_mode; ok = bus.btn_ok; nx = bus.btn_next;
        in = bus.btn_inc;  dc = bus.btn_dec;
        any = md | ok | nx | in | dc;
        act = any && !bus.ring_in;
        e_cancel = any && bus.ring_in;
        e_set = 0;
        case (m_ph)
            PH_IDLE: if (act) begin
                if (md) begin
                    m_ph = PH_LOAD;
                    m_left = LW;
                end else if (!ok && !nx) begin
                    if (in) m_sel = (m_sel + 1) % 3;
                    else if (dc) m_sel = (m_sel + 2) % 3;
                end
            end
            PH_LOAD: begin
                if (act && md) m_ph = PH_IDLE;
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_h = san(bus.cur_hour_bcd, 23);
                        m_m = san(bus.cur_minute_bcd, 59);
                        m_s = san(bus.cur_second_bcd, 59);
                        m_fld = 0; m_idle = 0; m_ph = PH_EDIT;
                    end
                end
            end
            PH_EDIT: begin
                if (act) begin
                    m_idle = 0;
                    if (md) m_ph = PH_IDLE;
                    else if (ok) begin m_ph = PH_COMMIT; e_set = 1; end
                    else if (nx) m_fld = (m_fld + 1) % 3;
                    else bump(in ? 1 : -1);
                end else begin
                    m_idle++;
                    if (m_idle == TO) m_ph = PH_IDLE;
                end
            end
            default: m_ph = PH_IDLE;
        endcase
    endtask

    task automatic check_all();
        check("sel", bus.selected_alarm, m_sel);
        check("set", bus.set, e_set);
        check("hour", bus.hour_bcd_out, i2b(m_h));
        check("min", bus.minute_bcd_out, i2b(m_m));
        check("sec", bus.second_bcd_out, i2b(m_s));
        check("active", bus.edit_active, m_ph != PH_IDLE);
        check("field", bus.edit_field, (m_ph == PH_EDIT) ? m_fld : 3);
        check("cancel", bus.cancel, e_cancel);
`ifndef ALARM_CTRL_BLINK_EN
        check("blink", bus.blink, 0);
`endif
    endtask

    // Called at a falling edge; applies buttons for one rising edge.
    task automatic step(input logic [4:0] b, input logic r);
        {bus.btn_mode, bus.btn_ok, bus.btn_next,
         bus.btn_inc, bus.btn_dec} = b;
        bus.ring_in = r;
        @(posedge clk);
        model_step();
        @(negedge clk);
        {bus.btn_mode, bus.btn_ok, bus.btn_next,
         bus.btn_inc, bus.btn_dec} = B_NONE;
        bus.ring_in = 1'b0;
        check_all();
    endtask

    task automatic enter_edit();
        step(B_MODE, 1'b0);
        repeat (LW) step(B_NONE, 1'b0);
    endtask

    initial begin
        {bus.btn_mode, bus.btn_ok, bus.btn_next,
         bus.btn_inc, bus.btn_dec} = B_NONE;
        bus.ring_in = 1'b0;
        bus.cur_hour_bcd = 8'h00;
        bus.cur_minute_bcd = 8'h00;
        bus.cur_second_bcd = 8'h00;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        check("rst_field", bus.edit_field, 2'd3);
        rst_n = 1'b1;

        step(B_INC, 1'b0); check("sel_1", bus.selected_alarm, 1);
        step(B_INC, 1'b0); check("sel_2", bus.selected_alarm, 2);
        step(B_INC, 1'b0); check("sel_0", bus.selected_alarm, 0);
        step(B_DEC, 1'b0); check("sel_dec", bus.selected_alarm, 2);
        step(B_INC, 1'b0);
        step(B_INC, 1'b0);

        bus.cur_hour_bcd = 8'h23;
        bus.cur_minute_bcd = 8'h59;
        bus.cur_second_bcd = 8'h58;
        enter_edit();
        check("load_h", bus.hour_bcd_out, 8'h23);
        check("load_m", bus.minute_bcd_out, 8'h59);
        check("load_s", bus.second_bcd_out, 8'h58);
        check("load_fld", bus.edit_field, 0);
        step(B_INC, 1'b0); check("h_wrap", bus.hour_bcd_out, 8'h00);

        step(B_NEXT, 1'b0);
        step(B_DEC, 1'b0); check("m_dec", bus.minute_bcd_out, 8'h58);
        step(B_NEXT, 1'b0);
        step(B_INC, 1'b0);
        step(B_INC, 1'b0); check("s_wrap", bus.second_bcd_out, 8'h00);
        step(B_OK, 1'b0);
        check("commit_set", bus.set, 1);
        check("commit_sel", bus.selected_alarm, 1);
        step(B_NONE, 1'b0);
        check("set_1cyc", bus.set, 0);
        check("commit_idle", bus.edit_active, 0);

        enter_edit();
        step(B_NEXT, 1'b0);
        step(B_INC, 1'b1);
        check("ring_cancel", bus.cancel, 1);
        check("ring_min", bus.minute_bcd_out, 8'h59);
        check("ring_fld", bus.edit_field, 1);
        step(B_NONE, 1'b0);
        check("cancel_1cyc", bus.cancel, 0);

        step(B_NEXT, 1'b0);
        step(B_MODE | B_OK, 1'b0);
        check("abort_idle", bus.edit_active, 0);
        check("abort_noset", bus.set, 0);
        step(B_NONE, 1'b0);
        check("abort_noset2", bus.set, 0);

        enter_edit();
        repeat (TO - 1) step(B_NONE, 1'b0);
        check("tmo_before", bus.edit_active, 1);
        step(B_NONE, 1'b0);
        check("tmo_idle", bus.edit_active, 0);
        check("tmo_noset", bus.set, 0);

        for (int i = 0; i < 3000; i++) begin
            logic [4:0] b;
            b[4] = ($urandom_range(0, 99) < 3);
            b[3] = ($urandom_range(0, 99) < 4);
            b[2] = ($urandom_range(0, 99) < 8);
            b[1] = ($urandom_range(0, 99) < 10);
            b[0] = ($urandom_range(0, 99) < 10);
            bus.cur_hour_bcd = rand_bcd(23);
            bus.cur_minute_bcd = rand_bcd(59);
            bus.cur_second_bcd = rand_bcd(59);
            step(b, $urandom_range(0, 99) < 15);
        end

        bus.cur_hour_bcd = 8'h12;
        bus.cur_minute_bcd = 8'h34;
        bus.cur_second_bcd = 8'h56;
        enter_edit();
        step(B_INC, 1'b0);
        check("pre_rst_h", bus.hour_bcd_out, 8'h13);
        @(posedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        check("async_rst_act", bus.edit_active, 0);
        check("async_rst_h", bus.hour_bcd_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step(B_NONE, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
- Sequences the alarm block from user buttons. Browses among the 3 alarm slots, preloads the selected slot's hour/minute/second, edits them field-by-field, and commits with a 1-cycle set pulse.
- Also generates the ring cancel pulse.
- Sits between the button debouncers and the alarm block at the clock top level.
- The alarm year/month/day inputs are driven by the top level from the current date and are out of scope here.

Parameters:
- LOAD_WAIT, 4, cycles to wait after selecting a slot before sampling the preload inputs (covers the alarm block's display-path latency).
- TIMEOUT_CYCLES, 1_000_000_000, cycles of no button activity in an edit state before the edit aborts (10 s at 100 MHz).
- BLINK_HALF, 25_000_000, half-period of the blink output in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- btn_mode  in  1  1-cycle pulse: enter edit, or abort edit
- btn_next  in  1  1-cycle pulse: advance edit field
- btn_inc  in  1  1-cycle pulse: increment
- btn_dec  in  1  1-cycle pulse: decrement
- btn_ok  in  1  1-cycle pulse: commit
- ring_in  in  1  ring output of the alarm block
- cur_hour_bcd  in  8  selected alarm's hour from the alarm block
- cur_minute_bcd  in  8  selected alarm's minute
- cur_second_bcd  in  8  selected alarm's second
- selected_alarm  out  2  slot index, 0..2
- set  out  1  1-cycle commit strobe
- hour_bcd_out  out  8  edited hour
- minute_bcd_out  out  8  edited minute
- second_bcd_out  out  8  edited second
- edit_active  out  1  high in LOAD, EDIT_H, EDIT_M, EDIT_S and COMMIT
- edit_field  out  2  0=hour, 1=minute, 2=second; 3 when not editing
- cancel  out  1  1-cycle ring cancel
- blink  out  1  field blink for the display

Behaviour:
- Reset (asynchronous): state IDLE, selected_alarm=0, set=0, all BCD outputs 8'h00, edit_active=0, edit_field=3, cancel=0, blink=0, all counters 0.
- All outputs are registered.
- Ring override:
  - While ring_in=1, any button pulse produces cancel=1 on the next cycle, for exactly 1 cycle.
  - That pulse has no other effect; the FSM state is unchanged.
  - If ring_in=0, cancel stays 0.
- Button priority when several pulses coincide: mode > ok > next > inc > dec. Only the highest-priority pulse acts.
- IDLE:
  - inc: selected_alarm 0→1→2→0.
  - dec: selected_alarm 0→2→1→0.
  - mode: go to LOAD.
  - next and ok: ignored.
- LOAD:
  - Counts LOAD_WAIT cycles, then captures cur_*_bcd into the *_out registers and goes to EDIT_H.
  - mode during LOAD aborts to IDLE.
  - All other buttons are ignored.
- EDIT_H / EDIT_M / EDIT_S:
  - inc/dec steps the active field in BCD with wrap: hour 00..23, minute and second 00..59 (23+1→00, 00-1→23, 59+1→00, 00-1→59).
  - Captured inputs with an invalid BCD digit or an out-of-range value are forced to 00 at capture.
  - next cycles H→M→S→H.
  - ok goes to COMMIT.
  - mode aborts to IDLE; no set is issued and the *_out registers keep their values.
- COMMIT: set=1 for exactly one cycle while selected_alarm is held stable, then IDLE.
- selected_alarm never changes outside IDLE.
- Timeout:
  - The inactivity counter resets on any button pulse and on entry to LOAD.
  - It counts only in EDIT_*. On reaching TIMEOUT_CYCLES-1 the FSM goes to IDLE with no set.
  - The counter width is $clog2(TIMEOUT_CYCLES).
- edit_field follows the state: EDIT_H=0, EDIT_M=1, EDIT_S=2, otherwise 3.

Optional Feature:
- Macro: ALARM_CTRL_BLINK_EN.
- Defined:
  - blink toggles every BLINK_HALF cycles while in EDIT_*, and is 0 elsewhere.
  - Any inc/dec forces blink=1 and restarts the blink counter, so the new value is visible immediately.
- Undefined: blink is tied 0 and no blink counter is synthesised.

Decomposition:
- Package alarm_ctrl_pkg:
  - state enum IDLE, LOAD, EDIT_H, EDIT_M, EDIT_S, COMMIT
  - field codes FIELD_HOUR=0, FIELD_MIN=1, FIELD_SEC=2, FIELD_NONE=3
  - BCD limits HOUR_MAX_BCD=8'h23, MINSEC_MAX_BCD=8'h59
  - NUM_ALARMS=3
- Sub-module bcd_field_step: combinational. Inputs value[7:0], max_bcd[7:0], inc, dec. Output is the wrapped next value, with invalid input mapped to 00. Instantiated once and muxed on the active field.

Test Plan:
- Reset, then 3× btn_inc → selected_alarm sequence 1, 2, 0. Then 1× btn_dec → 2.
- Select slot 1 with cur=23:59:58, then btn_mode → after LOAD_WAIT cycles outputs 8'h23/8'h59/8'h58, edit_field=0. Then btn_inc → hour 8'h00.
- In edit: next, dec, next, inc, inc, then ok → minute 8'h58, second 8'h00, and set high for exactly 1 cycle with selected_alarm=1.
- ring_in=1 in EDIT_M, then btn_inc → cancel high for 1 cycle, minute unchanged, state unchanged.
- Simultaneous btn_mode and btn_ok in EDIT_S → returns to IDLE, set never asserted.
- TIMEOUT_CYCLES=100 in simulation, no buttons in EDIT_H → IDLE after 100 cycles with no set. Assert rst_n mid-edit → all outputs at their reset values immediately.
